// File: rtl/ber_stat_accum_pkg.sv
// Shared types and constants for the BER/FER statistics accumulator and the
// upstream error-bit counter stage.
package ber_stat_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ber_state_t;

   // Block length and err_count width, common to the error-bit counter stage
   localparam int unsigned BER_N     = 204;
   localparam int unsigned BER_ERR_W = 8;

   // Guard bits appended above an accumulator so an add's carry-out is visible
   localparam int unsigned SAT_CARRY_W = 1;

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator: value += inc when enabled, clamps at all-ones.
// sat pulses on any enabled add whose result had to be clamped.
module sat_acc
   import ber_stat_accum_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             eval_clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] inc,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             sat
);

   logic [WIDTH-1:0]             acc_q;
   logic [WIDTH+SAT_CARRY_W-1:0] sum;
   logic                         ovf;

   // Widened sum exposes the carry that signals an overflowing add
   always_comb begin
      sum   = {{SAT_CARRY_W{1'b0}}, acc_q} + {{SAT_CARRY_W{1'b0}}, inc};
      ovf   = |sum[WIDTH+SAT_CARRY_W-1:WIDTH];
      sat   = en & ~clr & ovf;
      value = acc_q;
   end

   // Accumulator register; clear wins over an enabled add
   always_ff @(posedge eval_clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= ovf ? '1 : sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ber_stat_accum.sv
// Monte-Carlo BER/FER statistics accumulator. Detects one frame event per
// count_done pulse, samples err_count, and updates frame, frame-error, bit-error
// and worst-frame statistics one cycle later. Stops on a frame or frame-error
// target and holds results until restarted or cleared.
module ber_stat_accum
   import ber_stat_accum_pkg::*;
#(
   parameter int unsigned N     = BER_N,
   parameter int unsigned ERR_W = BER_ERR_W,
   parameter int unsigned FRM_W = 32,
   parameter int unsigned FER_W = 16,
   parameter int unsigned ACC_W = 40
) (
   input  logic             eval_clk,
   input  logic             rstn,
   input  logic [ERR_W-1:0] err_count,
   input  logic             count_done,
   input  logic             start,
   input  logic             clear,
   input  logic [FRM_W-1:0] max_frames,
   input  logic [FER_W-1:0] max_frame_err,
   output logic [ACC_W-1:0] total_err_bits,
   output logic [FRM_W-1:0] frame_cnt,
   output logic [FER_W-1:0] frame_err_cnt,
   output logic [ERR_W-1:0] max_err_seen,
   output logic             running,
   output logic             done,
   output logic             sat_flag,
   output logic             range_flag
);

   localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);
   localparam logic [FER_W-1:0] FER_ONE = FER_W'(1);

   ber_state_t       state_q, state_d;
   logic             cd_prev, frame_evt;
   logic [ERR_W-1:0] smp;
   logic             smp_v, smp_nz;
   logic             upd, term, zero_stats, acc_clr;
   logic [FRM_W-1:0] fc_nxt;
   logic [FER_W-1:0] fe_nxt;
   logic             sat_tot, sat_fc, sat_fe;

   // Event detect, stage-2 enable and post-update values for the target test
   always_comb begin
      frame_evt = count_done & ~cd_prev;
      upd       = smp_v & (state_q == ST_RUN);
      smp_nz    = |smp;
      fc_nxt    = (frame_cnt == '1) ? frame_cnt : frame_cnt + FRM_ONE;
      fe_nxt    = (smp_nz && frame_err_cnt != '1) ? frame_err_cnt + FER_ONE : frame_err_cnt;
      term      = upd & (((max_frames != '0) && (fc_nxt == max_frames)) ||
                         ((max_frame_err != '0) && (fe_nxt == max_frame_err)));
   end

   // Next-state logic; clear overrides everything
   always_comb begin
      state_d    = state_q;
      zero_stats = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start) begin
               state_d    = ST_RUN;
               zero_stats = 1'b1;
            end
            ST_RUN: if (term) state_d = ST_DONE;
            ST_DONE: if (start) begin
               state_d    = ST_RUN;
               zero_stats = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      acc_clr = clear | zero_stats;
      running = (state_q == ST_RUN);
      done    = (state_q == ST_DONE);
   end

   // State register
   always_ff @(posedge eval_clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Stage 1: edge-detect register and sample latch; an event coinciding with
   // the terminating update is dropped so the run ends on the exact target
   always_ff @(posedge eval_clk or negedge rstn) begin
      if (!rstn) begin
         cd_prev <= 1'b0;
         smp     <= '0;
         smp_v   <= 1'b0;
      end else if (clear) begin
         cd_prev <= 1'b0;
         smp     <= '0;
         smp_v   <= 1'b0;
      end else begin
         cd_prev <= count_done;
         smp_v   <= (state_q == ST_RUN) & frame_evt & ~term;
         if ((state_q == ST_RUN) && frame_evt && !term) smp <= err_count;
      end
   end

   // Stage 2: worst-frame tracking and sticky flags
   always_ff @(posedge eval_clk or negedge rstn) begin
      if (!rstn) begin
         max_err_seen <= '0;
         range_flag   <= 1'b0;
         sat_flag     <= 1'b0;
      end else if (acc_clr) begin
         max_err_seen <= '0;
         range_flag   <= 1'b0;
         sat_flag     <= 1'b0;
      end else if (upd) begin
         if (smp > max_err_seen) max_err_seen <= smp;
         if (32'(smp) > N)       range_flag   <= 1'b1;
         if (sat_tot | sat_fc | sat_fe) sat_flag <= 1'b1;
      end
   end

   sat_acc #(.WIDTH(ACC_W)) u_tot_acc (
      .eval_clk (eval_clk),
      .rstn     (rstn),
      .inc      ({{(ACC_W-ERR_W){1'b0}}, smp}),
      .en       (upd),
      .clr      (acc_clr),
      .value    (total_err_bits),
      .sat      (sat_tot)
   );

   sat_acc #(.WIDTH(FRM_W)) u_fc_acc (
      .eval_clk (eval_clk),
      .rstn     (rstn),
      .inc      (FRM_ONE),
      .en       (upd),
      .clr      (acc_clr),
      .value    (frame_cnt),
      .sat      (sat_fc)
   );

   sat_acc #(.WIDTH(FER_W)) u_fe_acc (
      .eval_clk (eval_clk),
      .rstn     (rstn),
      .inc      ({{(FER_W-1){1'b0}}, smp_nz}),
      .en       (upd),
      .clr      (acc_clr),
      .value    (frame_err_cnt),
      .sat      (sat_fe)
   );

endmodule

// File: doc/ber_stat_accum.md
Name: ber_stat_accum

Overview:
- Downstream consumer of the per-frame error-bit counter (err_count / count_done pair). Accumulates Monte-Carlo BER/FER statistics across decoded frames in the eval_clk domain.
- Counts frames, frame errors, total bit errors and worst-frame error count.
- Stops automatically on a frame-count or frame-error target, then holds results for readout by the test harness.

Parameters:
- N, 204, block length; err_count values above N are flagged as out-of-range.
- ERR_W, 8, width of incoming err_count.
- FRM_W, 32, width of frame counter and max_frames.
- FER_W, 16, width of frame-error counter and max_frame_err.
- ACC_W, 40, width of total bit-error accumulator.

Ports:
- eval_clk  in  1  clock, same domain as the error-bit counter.
- rstn  in  1  asynchronous active-low reset.
- err_count  in  ERR_W  per-frame error-bit count from the counter stage.
- count_done  in  1  result-valid from the counter stage; asserted for 2 consecutive cycles per frame.
- start  in  1  single-cycle pulse; begins a measurement run.
- clear  in  1  synchronous clear of all statistics and flags; returns to IDLE.
- max_frames  in  FRM_W  frame target; 0 means unlimited.
- max_frame_err  in  FER_W  frame-error target; 0 means unlimited.
- total_err_bits  out  ACC_W  sum of err_count over accepted frames.
- frame_cnt  out  FRM_W  accepted frames.
- frame_err_cnt  out  FER_W  accepted frames with err_count != 0.
- max_err_seen  out  ERR_W  largest accepted err_count.
- running  out  1  high in RUN.
- done  out  1  high in DONE (level).
- sat_flag  out  1  sticky; some accumulator saturated.
- range_flag  out  1  sticky; an accepted err_count was > N.

Behaviour:
- Reset (rstn low, async): all outputs 0, FSM in IDLE, edge-detect register 0, sample-valid 0. Same values apply on clear (sync), which has priority over every other input in every state.
- Edge detect: cd_prev registered copy of count_done; frame event = count_done & ~cd_prev. Each 2-cycle pulse yields exactly one event. A count_done held high longer still yields one event.
- FSM:
  - IDLE: start -> RUN. Statistics are zeroed on this transition.
  - RUN: events accepted. Termination -> DONE. start ignored.
  - DONE: results held; events ignored. start -> RUN with statistics zeroed. clear -> IDLE.
- Pipeline in RUN:
  - Stage 1: on an event, latch err_count into smp and set smp_v.
  - Stage 2, on the cycle after the event:
    - frame_cnt += 1
    - total_err_bits += smp
    - frame_err_cnt += (smp != 0)
    - max_err_seen = max(max_err_seen, smp)
    - range_flag |= (smp > N)
  - Latency: event cycle t; statistics visible at t+2 (registered outputs).
- Termination is evaluated on the post-update values in stage 2: (max_frames != 0 && frame_cnt_next == max_frames) || (max_frame_err != 0 && frame_err_cnt_next == max_frame_err). On a hit, state = DONE at t+2, running falls and done rises in the same cycle.
- An event arriving in the same cycle as the terminating stage-2 update is discarded; its sample is not counted.
- Targets are sampled live. Changing max_frames or max_frame_err mid-run below the current count means the equality never fires, and the run continues until clear.
- Saturation: every counter saturates at all-ones and does not wrap. Any saturation sets sat_flag. Saturation does not by itself terminate the run.
- Width rules: smp is zero-extended to ACC_W before the add. Comparisons are unsigned.
- Reset mid-run: all state is lost, IDLE. A partially latched sample is dropped.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, DONE), N / ERR_W default constants (shared with the error-bit counter stage), and a saturating-add width helper constant.
- Sub-module: sat_acc (parameterised WIDTH; inputs inc, en, clr; outputs value, sat). Instantiated for total_err_bits, frame_cnt and frame_err_cnt.

Test Plan:
- Reset/start, max_frames=3, err_count 0,5,0 each with 2-cycle count_done -> frame_cnt=3, frame_err_cnt=1, total_err_bits=5, max_err_seen=5, done=1 two cycles after the 3rd event.
- max_frames=0, max_frame_err=2, err_counts 0,7,0,12 -> done after the 4th event; frame_cnt=4, total=19, max_err_seen=12.
- count_done held high for 5 cycles with err_count=9 -> exactly one frame counted (frame_cnt=1, total=9).
- err_count=210 (> N) accepted -> range_flag=1 and stays set; total increases by 210.
- Force frame_err_cnt to 16'hFFFE, then 3 erroneous frames -> frame_err_cnt stuck at 16'hFFFF, sat_flag=1, running stays 1.
- rstn pulsed low mid-run after 2 frames, or clear asserted in DONE -> all outputs 0 and state IDLE; subsequent events are ignored until start.
